display_formatter: RTL

Parametrised successor to the current 2-digit option controller. Captures a register-write value or the PC on a write strobe and formats it for an N-digit display. Supports hex, decimal (sequential double-dabble), and signed-magnitude modes. Sits between the CPU datapath (writeback data, PC, control) and the seven-segment digit mux/decoder.

---
 rtl/display_formatter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/display_formatter.sv
// Captures a write-back value or PC on REG_WRITE and formats it as N display
// digit codes (hex, sequential double-dabble decimal, or signed-magnitude).
module display_formatter #(
  parameter int DATA_W = 8,
  parameter int DIGITS = 6
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [2:0]          DIP,
  input  logic                REG_WRITE,
  input  logic [DATA_W-1:0]   REG_WRITE_DATA,
  input  logic [DATA_W-1:0]   PC,
  output logic [5*DIGITS-1:0] OUT,
  output logic                BUSY,
  output logic                DONE
);
  function automatic int dec_digits(input int w);
    longint v;
    int     n;
    v = (longint'(1) << w) - 1;
    n = 0;
    for (int i = 0; i < 8; i++) if (v > 0) begin n++; v = v / 10; end
    return n;
  endfunction

  localparam int HEX_D = (DATA_W + 3) / 4;
  localparam int DEC_D = dec_digits(DATA_W);
  localparam int CNT_W = $clog2(DATA_W);
  localparam int SH_W  = 4 * DEC_D + DATA_W;
  localparam logic [4:0] BLANK = 5'h10, DASH = 5'h11, OVF = 5'h12;

  typedef struct packed {
    logic              dec;
    logic              neg;
    logic [DATA_W-1:0] mag;
  } req_t;

  typedef enum logic [1:0] {IDLE, CONV, EMIT} state_t;

  function automatic req_t capture(input logic [2:0] dip,
                                   input logic [DATA_W-1:0] data,
                                   input logic [DATA_W-1:0] pc);
    req_t              r;
    logic [DATA_W-1:0] v;
    v     = dip[0] ? pc : data;
    r.dec = dip[2];
    r.neg = dip[1] & ~dip[0] & v[DATA_W-1];
    r.mag = r.neg ? -v : v;
    return r;
  endfunction

  state_t                   state, state_nxt;
  req_t                     cur, pend, in_req, nxt_req;
  logic                     pend_vld, load;
  logic [4*DEC_D-1:0]       bcd, bcd_adj;
  logic [DATA_W-1:0]        bin;
  logic [CNT_W-1:0]         cnt;
  logic [SH_W-1:0]          sh;
  logic [4*HEX_D-1:0]       mag_ext;
  logic [DIGITS-1:0][4:0]   fmt_c, fmt_q, out_q;
  logic                     fmt_vld;
  int                       nd;

  // A write in the EMIT cycle is newer than anything parked in the slot.
  always_comb begin
    in_req    = capture(DIP, REG_WRITE_DATA, PC);
    nxt_req   = (state == EMIT && !REG_WRITE) ? pend : in_req;
    load      = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: if (REG_WRITE) load = 1'b1;
      CONV: if (cnt == CNT_W'(DATA_W - 1)) state_nxt = EMIT;
      EMIT: begin
        state_nxt = IDLE;
        if (REG_WRITE || pend_vld) load = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    if (load) state_nxt = nxt_req.dec ? CONV : EMIT;
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    bcd_adj = bcd;
    for (int d = 0; d < DEC_D; d++)
      if (bcd[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    sh = {bcd_adj, bin};
  end

  always_comb begin
    fmt_c   = '{default: BLANK};
    mag_ext = '0;
    mag_ext[DATA_W-1:0] = cur.mag;
    nd = HEX_D;
    if (cur.dec) begin
      nd = 1;
      for (int d = 0; d < DEC_D; d++) if (bcd[4*d +: 4] != 4'd0) nd = d + 1;
    end
    if (nd + int'(cur.neg) > DIGITS) begin
      fmt_c = '{default: OVF};
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (i < nd)
          fmt_c[i] = {1'b0, cur.dec ? 4'(bcd >> (4*i)) : 4'(mag_ext >> (4*i))};
        else if (i == nd && cur.neg)
          fmt_c[i] = DASH;
      end
    end
  end

  // EMIT latches the formatted digits; they reach OUT one edge later with DONE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_vld <= 1'b0;
      fmt_vld  <= 1'b0;
      DONE     <= 1'b0;
      cnt      <= '0;
      out_q    <= '{default: DASH};
    end else begin
      if (load) begin
        cur <= nxt_req;
        bin <= nxt_req.mag;
        bcd <= '0;
        cnt <= '0;
      end else if (state == CONV) begin
        {bcd, bin} <= {sh[SH_W-2:0], 1'b0};
        cnt        <= cnt + 1'b1;
      end
      if (state == EMIT) begin
        pend_vld <= 1'b0;
      end else if (state != IDLE && REG_WRITE) begin
        pend     <= in_req;
        pend_vld <= 1'b1;
      end
      fmt_vld <= (state == EMIT);
      if (state == EMIT) fmt_q <= fmt_c;
      DONE <= fmt_vld;
      if (fmt_vld) out_q <= fmt_q;
    end
  end

  assign OUT  = out_q;
  assign BUSY = (state != IDLE);
endmodule
